horner_seq: RTL and testbench

HORNER_SEQ -- requirements
Module: horner_seq

---
 rtl/horner_seq_if.sv | 27 ++
 rtl/horner_seq.sv | 108 ++++++++++
 tb/tb_horner_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/horner_seq_if.sv
// rtl/horner_seq_if.sv - sample, coefficient-config and datapath-control bundle of horner_seq
interface horner_seq_if;
    logic        x_valid;
    logic        x_ready;
    logic [31:0] x_in;
    logic        abort;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] x_adc_smc;
    logic        srdyi_i;
    logic [31:0] coeff;
    logic        sum_en;
    logic        sum_rst;
    logic        busy;
    logic        lin_valid;

    modport master (
        output x_valid, x_in, abort, cfg_we, cfg_addr, cfg_wdata,
        input  x_ready, x_adc_smc, srdyi_i, coeff, sum_en, sum_rst, busy, lin_valid
    );

    modport slave (
        input  x_valid, x_in, abort, cfg_we, cfg_addr, cfg_wdata,
        output x_ready, x_adc_smc, srdyi_i, coeff, sum_en, sum_rst, busy, lin_valid
    );
endinterface

// File: rtl/horner_seq.sv
// rtl/horner_seq.sv - Horner polynomial evaluation sequencer driving an external float datapath
module horner_seq #(
    parameter int ORDER    = 10,
    parameter int LOOP_LAT = 4,
    parameter int CONV_LAT = 2
) (
    input  logic         clk,
    input  logic         GlobalReset,
    horner_seq_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_ACCUM = 3'd4;
    localparam logic [2:0] S_FLUSH = 3'd5;

    // Counter only has to hold the larger of the two reload values.
    localparam int CNT_MAX = (LOOP_LAT > CONV_LAT) ? LOOP_LAT : CONV_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [3:0]    K_MAX      = 4'(ORDER);
    localparam logic [CW-1:0] WAIT_LOAD  = CW'(LOOP_LAT - 2);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(CONV_LAT - 1);

    logic [2:0]    r_state;
    logic [3:0]    r_k;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_x;
    logic [31:0]   r_coef [0:ORDER];

    logic          w_abort;
    logic          w_cfg_wr;
    logic [31:0]   w_coef_k;
    logic          w_loop_st;

    // Abort only matters once an evaluation is running; in IDLE it is a don't-care.
    assign w_abort   = bus.abort && (r_state != S_IDLE);
    assign w_cfg_wr  = bus.cfg_we && (r_state == S_IDLE) && (bus.cfg_addr <= K_MAX);
    assign w_coef_k  = (r_k <= K_MAX) ? r_coef[r_k] : 32'd0;
    assign w_loop_st = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_ACCUM);

    // Sequencer: one Horner step per ISSUE/WAIT/ACCUM round, k counts ORDER down to 0.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_state <= S_IDLE;
            r_k     <= K_MAX;
            r_cnt   <= '0;
            r_x     <= '0;
        end else if (w_abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.x_valid) begin
                        r_x     <= bus.x_in;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_k     <= K_MAX;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_cnt   <= WAIT_LOAD;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) r_state <= S_ACCUM;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                S_ACCUM: begin
                    if (r_k == '0) begin
                        r_cnt   <= FLUSH_LOAD;
                        r_state <= S_FLUSH;
                    end else begin
                        r_k     <= r_k - 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == '0) r_state <= S_IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Coefficient bank: writable only while idle so a running evaluation never sees a torn set.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            for (int i = 0; i <= ORDER; i++) r_coef[i] <= '0;
        end else if (w_cfg_wr) begin
            r_coef[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    // Pulses toward the datapath are squashed in an abort cycle so nothing half-issued leaks out.
    assign bus.x_ready   = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.x_adc_smc = r_x;
    assign bus.sum_rst   = (r_state == S_CLEAR);
    assign bus.srdyi_i   = (r_state == S_ISSUE) && !w_abort;
    assign bus.sum_en    = (r_state == S_ACCUM) && !w_abort;
    assign bus.lin_valid = (r_state == S_FLUSH) && (r_cnt == '0) && !w_abort;
    assign bus.coeff     = w_loop_st ? w_coef_k : 32'd0;
endmodule

// File: tb/tb_horner_seq.sv
// tb/tb_horner_seq.sv - randomized self-checking bench for horner_seq against a cycle-schedule model
module tb_horner_seq;
    localparam int ORDER    = 10;
    localparam int LOOP_LAT = 4;
    localparam int CONV_LAT = 2;
    localparam int P        = LOOP_LAT + 1;
    localparam int T_END    = 1 + (ORDER + 1) * P + CONV_LAT;

    logic clk;
    logic rst_n;
    horner_seq_if u_if ();

    horner_seq #(.ORDER(ORDER), .LOOP_LAT(LOOP_LAT), .CONV_LAT(CONV_LAT)) u_dut (
        .clk         (clk),
        .GlobalReset (rst_n),
        .bus         (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    int          cyc;
    bit          m_active;
    int          m_acc;
    logic [31:0] m_samp;
    logic [31:0] m_coef [0:ORDER];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Expected outputs come from the acceptance-relative cycle number t.
    task automatic check_all();
        int t, u, j, ph;
        logic e_rdy, e_busy, e_rst, e_iss, e_en, e_lin;
        logic [31:0] e_coef;
        e_rdy = 1; e_busy = 0; e_rst = 0; e_iss = 0; e_en = 0; e_lin = 0; e_coef = 0;
        if (m_active) begin
            t = cyc - m_acc;
            e_rdy = 0; e_busy = 1;
            if (t == 1) e_rst = 1;
            else if (t <= 1 + (ORDER + 1) * P) begin
                u = t - 2; j = u / P; ph = u % P;
                e_coef = m_coef[ORDER - j];
                e_iss  = (ph == 0) && !u_if.abort;
                e_en   = (ph == P - 1) && !u_if.abort;
            end else if (t == T_END) e_lin = !u_if.abort;
        end
        chk("x_ready",   32'(u_if.x_ready),   32'(e_rdy));
        chk("busy",      32'(u_if.busy),      32'(e_busy));
        chk("sum_rst",   32'(u_if.sum_rst),   32'(e_rst));
        chk("srdyi_i",   32'(u_if.srdyi_i),   32'(e_iss));
        chk("sum_en",    32'(u_if.sum_en),    32'(e_en));
        chk("lin_valid", 32'(u_if.lin_valid), 32'(e_lin));
        chk("coeff",     u_if.coeff,          e_coef);
        chk("x_adc_smc", u_if.x_adc_smc,      m_samp);
    endtask

    task automatic run_cycle(input logic xv, input logic [31:0] xi, input logic ab,
                             input logic we, input logic [3:0] ad, input logic [31:0] wd);
        @(posedge clk); #1;
        u_if.x_valid = xv; u_if.x_in = xi; u_if.abort = ab;
        u_if.cfg_we = we; u_if.cfg_addr = ad; u_if.cfg_wdata = wd;
        @(negedge clk);
        check_all();
        if (!m_active) begin
            if (we && int'(ad) <= ORDER) m_coef[ad] = wd;
            if (xv) begin m_active = 1; m_acc = cyc; m_samp = xi; end
        end else if (ab || (cyc - m_acc) == T_END) begin
            m_active = 0;
        end
        cyc++;
    endtask

    task automatic model_reset();
        m_active = 0; m_samp = 0;
        for (int i = 0; i <= ORDER; i++) m_coef[i] = 0;
    endtask

    task automatic async_reset();
        @(posedge clk); #1;
        rst_n = 0;
        u_if.x_valid = 0; u_if.abort = 0; u_if.cfg_we = 0;
        model_reset();
        #1 check_all();
        @(negedge clk); #1 rst_n = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        rst_n = 0;
        u_if.x_valid = 0; u_if.x_in = 0; u_if.abort = 0;
        u_if.cfg_we = 0; u_if.cfg_addr = 0; u_if.cfg_wdata = 0;
        model_reset();
        #12 check_all();
        @(negedge clk); #1 rst_n = 1;

        // Ramp coefficients c_k = k, one evaluation of x = 1.0
        for (int i = 0; i <= ORDER; i++) run_cycle(0, 0, 0, 1, 4'(i), 32'(i));
        run_cycle(1, 32'h3F80_0000, 0, 0, 0, 0);
        idle(T_END + 4);

        // x_valid held high over two samples: back-to-back acceptance
        for (int i = 0; i < 2 * (T_END + 1) + 3; i++) run_cycle(1, $urandom, 0, 0, 0, 0);
        idle(3);

        // Abort mid-loop, then abort on the lin_valid cycle
        run_cycle(1, $urandom, 0, 0, 0, 0);
        for (int i = 1; i <= T_END + 3; i++) run_cycle(0, 0, (i == 20), 0, 0, 0);
        run_cycle(1, $urandom, 0, 0, 0, 0);
        for (int i = 1; i <= T_END + 3; i++) run_cycle(0, 0, (i == T_END), 0, 0, 0);
        // Abort in IDLE alongside x_valid is ignored and the sample is taken
        run_cycle(1, 32'h4000_0000, 1, 0, 0, 0);
        idle(T_END + 2);

        // Config writes: busy write ignored, out-of-range ignored, c0 write lands
        run_cycle(1, $urandom, 0, 0, 0, 0);
        for (int i = 1; i <= T_END + 2; i++) run_cycle(0, 0, 0, (i == 10), 4'd3, 32'hDEAD_BEEF);
        run_cycle(0, 0, 0, 1, 4'd11, 32'hBAD0_0011);
        run_cycle(0, 0, 0, 1, 4'd0, 32'h1234_5678);
        run_cycle(1, $urandom, 0, 0, 0, 0);
        idle(T_END + 2);

        // Asynchronous reset mid-evaluation, then evaluate with cleared bank
        run_cycle(1, $urandom, 0, 0, 0, 0);
        idle(29);
        async_reset();
        idle(T_END + 2);
        run_cycle(1, $urandom, 0, 0, 0, 0);
        idle(T_END + 2);

        // Random traffic
        for (int i = 0; i <= ORDER; i++) run_cycle(0, 0, 0, 1, 4'(i), $urandom);
        for (int i = 0; i < 3000; i++)
            run_cycle(($urandom_range(3) == 0), $urandom, ($urandom_range(59) == 0),
                      ($urandom_range(7) == 0), 4'($urandom_range(15)), $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
